// File: rtl/ct_spsram_param_ctrl.sv
// rtl/ct_spsram_param_ctrl.sv - single-port SRAM with bit-write enables, 1/2-cycle read latency and init sweep (optional CT_SPSRAM_ACC_CNT_EN access counters)
module ct_spsram_param_ctrl #(
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    RD_LAT     = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  rd_vld,
    input  logic                  init_req,
    output logic                  init_busy,
`ifdef CT_SPSRAM_ACC_CNT_EN
    output logic                  init_done,
    output logic [15:0]           rd_cnt,
    output logic [15:0]           wr_cnt
`else
    output logic                  init_done
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_vld;
    logic                  w_acc;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_sweep_last;

    // The sweep owns the array: external requests are dropped while it runs.
    assign w_acc        = ~CEN & (r_state != ST_INIT);
    assign w_rd         = w_acc & GWEN;
    assign w_wr         = w_acc & ~GWEN;
    assign w_sweep_last = (r_cnt == {ADDR_WIDTH{1'b1}});
    assign init_busy    = (r_state == ST_INIT);
    assign init_done    = (r_state == ST_DONE);

    // State and sweep counter; reset always restarts the sweep from entry 0.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: INIT walks every entry once, DONE lasts one cycle, IDLE waits for a request.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                w_cnt_nxt = r_cnt + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                if (w_sweep_last) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (init_req) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Array update: sweep write, or a masked write where WEN bit 0 selects D.
    always_ff @(posedge forever_cpuclk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_cnt] <= INIT_VAL;
        end else if (w_wr) begin
            r_mem[A] <= (r_mem[A] & WEN) | (D & ~WEN);
        end
    end

    // First read stage: data only loads on an accepted read so Q holds otherwise.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
        end else begin
            r_s1_vld <= w_rd;
            if (w_rd) begin
                r_s1_data <= r_mem[A];
            end
        end
    end

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("ct_spsram_param_ctrl: RD_LAT must be 1 or 2");
    end

    if (RD_LAT == 2) begin : g_lat2
        logic                  r_s2_vld;
        logic [DATA_WIDTH-1:0] r_s2_data;

        // Extra output register for the two-cycle latency build.
        always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
            if (!cpurst_b) begin
                r_s2_vld  <= 1'b0;
                r_s2_data <= '0;
            end else begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign Q      = r_s2_data;
        assign rd_vld = r_s2_vld;
    end else begin : g_lat1
        assign Q      = r_s1_data;
        assign rd_vld = r_s1_vld;
    end

`ifdef CT_SPSRAM_ACC_CNT_EN
    logic        w_enter_init;
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;

    assign w_enter_init = (r_state == ST_IDLE) & init_req;
    assign rd_cnt       = r_rd_cnt;
    assign wr_cnt       = r_wr_cnt;

    // Saturating access counters, cleared whenever a new sweep starts.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (w_enter_init) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (w_rd && (r_rd_cnt != 16'hFFFF)) begin
                r_rd_cnt <= r_rd_cnt + 16'd1;
            end
            if (w_wr && (r_wr_cnt != 16'hFFFF)) begin
                r_wr_cnt <= r_wr_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ct_spsram_param_ctrl.sv
// tb/tb_ct_spsram_param_ctrl.sv - scoreboard bench for ct_spsram_param_ctrl at RD_LAT 1 and 2
module tb_ct_spsram_param_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  a;
    logic        cen;
    logic        gwen;
    logic [15:0] wen;
    logic [15:0] d;
    logic        init_req;

    logic [15:0] q1, q2;
    logic        vld1, vld2, busy1, busy2, done1, done2;
`ifdef CT_SPSRAM_ACC_CNT_EN
    logic [15:0] rdc1, wrc1, rdc2, wrc2;
`endif

    typedef struct packed {
        logic [15:0] d;
        logic [31:0] cyc;
    } exp_t;

    exp_t q_lat1[$];
    exp_t q_lat2[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ct_spsram_param_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(16), .RD_LAT(1), .INIT_VAL(16'h0000)) u_dut1 (
        .forever_cpuclk(clk), .cpurst_b(rst_n), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
        .Q(q1), .rd_vld(vld1), .init_req(init_req), .init_busy(busy1),
`ifdef CT_SPSRAM_ACC_CNT_EN
        .init_done(done1), .rd_cnt(rdc1), .wr_cnt(wrc1)
`else
        .init_done(done1)
`endif
    );

    ct_spsram_param_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(16), .RD_LAT(2), .INIT_VAL(16'h0000)) u_dut2 (
        .forever_cpuclk(clk), .cpurst_b(rst_n), .A(a), .CEN(cen), .GWEN(gwen), .WEN(wen), .D(d),
        .Q(q2), .rd_vld(vld2), .init_req(init_req), .init_busy(busy2),
`ifdef CT_SPSRAM_ACC_CNT_EN
        .init_done(done2), .rd_cnt(rdc2), .wr_cnt(wrc2)
`else
        .init_done(done2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_vld pops the oldest expected read and checks data and arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        if (vld1) begin
            if (q_lat1.size() == 0) chk("lat1_unexpected_rd_vld", 32'd1, 32'd0);
            else begin
                e = q_lat1.pop_front();
                chk("lat1_q", {16'h0, q1}, {16'h0, e.d});
                chk("lat1_cycle", cyc, e.cyc);
            end
        end
        if (vld2) begin
            if (q_lat2.size() == 0) chk("lat2_unexpected_rd_vld", 32'd1, 32'd0);
            else begin
                e = q_lat2.pop_front();
                chk("lat2_q", {16'h0, q2}, {16'h0, e.d});
                chk("lat2_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input logic [15:0] ex);
        exp_t e;
        e.d   = ex;
        e.cyc = cyc + 1;
        q_lat1.push_back(e);
        e.cyc = cyc + 2;
        q_lat2.push_back(e);
    endtask

    task automatic wr(input logic [6:0] ad, input logic [15:0] dd, input logic [15:0] ww);
        a = ad; d = dd; wen = ww; cen = 1'b0; gwen = 1'b0;
        step();
        cen = 1'b1; gwen = 1'b1; wen = 16'hFFFF;
    endtask

    task automatic rd(input logic [6:0] ad, input logic [15:0] ex);
        a = ad; cen = 1'b0; gwen = 1'b1;
        push_rd(ex);
        step();
        cen = 1'b1;
    endtask

    // Counts busy/done cycles over a window covering a whole sweep; optional read traffic while busy.
    task automatic sweep(input string tag, input bit traffic);
        int nb1 = 0, nb2 = 0, nd1 = 0, nd2 = 0;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (busy1) nb1++;
            if (busy2) nb2++;
            if (done1) nd1++;
            if (done2) nd2++;
            if (traffic && busy1) begin
                a = 7'(i); cen = 1'b0; gwen = 1'b1; init_req = (i == 50);
            end else begin
                cen = 1'b1; init_req = 1'b0;
            end
        end
        chk({tag, "_busy_cycles_lat1"}, nb1, 128);
        chk({tag, "_busy_cycles_lat2"}, nb2, 128);
        chk({tag, "_done_pulses_lat1"}, nd1, 1);
        chk({tag, "_done_pulses_lat2"}, nd2, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; a = '0; d = '0; wen = 16'hFFFF; cen = 1'b1; gwen = 1'b1; init_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_q1", {16'h0, q1}, 32'h0);
        chk("rst_vld1", {31'h0, vld1}, 32'h0);
        chk("rst_busy1", {31'h0, busy1}, 32'h1);
        chk("rst_done1", {31'h0, done1}, 32'h0);
        chk("rst_q2", {16'h0, q2}, 32'h0);
        chk("rst_vld2", {31'h0, vld2}, 32'h0);
        step();
        rst_n = 1'b1;
        sweep("por", 1'b0);

        rd(7'h33, 16'h0000);
        rd(7'h7F, 16'h0000);

        wr(7'h05, 16'hA5A5, 16'h0000);
        rd(7'h05, 16'hA5A5);

        wr(7'h20, 16'hFFFF, 16'h0000);
        wr(7'h20, 16'h0000, 16'hFF00);
        rd(7'h20, 16'hFF00);
        wr(7'h20, 16'h0000, 16'hFFFF);
        rd(7'h20, 16'hFF00);

        wr(7'h00, 16'h0011, 16'h0000);
        wr(7'h01, 16'h0022, 16'h0000);
        wr(7'h02, 16'h0033, 16'h0000);
        wr(7'h03, 16'h0044, 16'h0000);
        rd(7'h00, 16'h0011);
        rd(7'h01, 16'h0022);
        rd(7'h02, 16'h0033);
        rd(7'h03, 16'h0044);
        repeat (4) step();

        wr(7'h40, 16'hBEEF, 16'h0000);
        @(negedge clk);
        chk("q1_hold_after_write", {16'h0, q1}, 32'h0044);
        chk("q2_hold_after_write", {16'h0, q2}, 32'h0044);

        a = 7'h10; d = 16'h1234; wen = 16'h0000; cen = 1'b0; gwen = 1'b0; init_req = 1'b1;
        step();
        cen = 1'b1; gwen = 1'b1; wen = 16'hFFFF; init_req = 1'b0;
        sweep("req", 1'b1);
        rd(7'h10, 16'h0000);
        rd(7'h05, 16'h0000);
        repeat (4) step();

        wr(7'h05, 16'hA5A5, 16'h0000);
        a = 7'h05; cen = 1'b0; gwen = 1'b1; init_req = 1'b1;
        push_rd(16'hA5A5);
        step();
        cen = 1'b1; init_req = 1'b0;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_q1", {16'h0, q1}, 32'h0);
        chk("midrst_vld1", {31'h0, vld1}, 32'h0);
        chk("midrst_busy1", {31'h0, busy1}, 32'h1);
        chk("midrst_q2", {16'h0, q2}, 32'h0);
        chk("midrst_vld2", {31'h0, vld2}, 32'h0);
        chk("midrst_busy2", {31'h0, busy2}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep("rst", 1'b0);

        rd(7'h05, 16'h0000);
        rd(7'h10, 16'h0000);
        wr(7'h11, 16'h5555, 16'h0000);
        wr(7'h12, 16'h0001, 16'hFFFF);
        rd(7'h11, 16'h5555);
        repeat (4) step();
`ifdef CT_SPSRAM_ACC_CNT_EN
        chk("rd_cnt1", {16'h0, rdc1}, 32'd3);
        chk("wr_cnt1", {16'h0, wrc1}, 32'd2);
        chk("rd_cnt2", {16'h0, rdc2}, 32'd3);
        chk("wr_cnt2", {16'h0, wrc2}, 32'd2);
`endif
        chk("lat1_reads_outstanding", q_lat1.size(), 0);
        chk("lat2_reads_outstanding", q_lat2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ct_spsram_param_ctrl.md
Name: ct_spsram_param_ctrl

Overview:
Parametrised single-port SRAM macro with active-low bit-write enables and a configurable read latency (1 or 2 cycles).
It adds a hardware initialisation sequencer that clears every entry to INIT_VAL after reset or on request, and blocks external access while the sweep runs.
It is the drop-in successor for fixed-geometry IFU/LSU spsram instances such as 128x16 tag and valid arrays.

Parameters:
ADDR_WIDTH, 7, address bits; DEPTH = 2**ADDR_WIDTH entries.
DATA_WIDTH, 16, word width in bits.
RD_LAT, 1, read latency in cycles; legal values are 1 and 2 only; any other value is a configuration error.
INIT_VAL, 0, DATA_WIDTH-bit value written to every entry by the init sweep.

Ports:
forever_cpuclk  input  1  clock.
cpurst_b  input  1  asynchronous active-low reset.
A  input  ADDR_WIDTH  access address.
CEN  input  1  chip enable, active low.
GWEN  input  1  global write enable, active low (0 = write, 1 = read).
WEN  input  DATA_WIDTH  per-bit write enable, active low.
D  input  DATA_WIDTH  write data.
Q  output  DATA_WIDTH  read data.
rd_vld  output  1  one-cycle pulse when Q carries new read data.
init_req  input  1  single-cycle pulse requesting re-initialisation.
init_busy  output  1  high while the init sweep runs.
init_done  output  1  one-cycle pulse on the cycle after the final sweep write.

Behaviour:
- Storage array has no reset; only control state is reset by cpurst_b.
- Reset values: Q=0, rd_vld=0, init_busy=1, init_done=0, FSM=INIT, sweep counter=0.
- FSM states: IDLE, INIT, DONE.
  - INIT: writes INIT_VAL to entry[cnt] each cycle, cnt increments; on cnt==DEPTH-1 the write completes and FSM moves to DONE. Sweep length is exactly DEPTH cycles.
  - DONE: one cycle; asserts init_done; FSM moves to IDLE. init_busy=0 from DONE onward.
  - IDLE: init_req=1 moves FSM to INIT with cnt=0 next cycle. Any access presented in that same cycle is still performed.
- init_req is ignored in INIT and DONE; there is no restart.
- While FSM is INIT, external CEN is treated as 1: requests are dropped, rd_vld stays 0, and Q holds its value.
- Write (CEN=0, GWEN=0): on the clock edge, bit i of entry[A] is set to D[i] wherever WEN[i]=0. Other bits are unchanged. WEN all-ones is a legal no-op. Q and rd_vld are unaffected.
- Read (CEN=0, GWEN=1): the array is sampled at the edge.
  - RD_LAT=1: Q is valid and rd_vld=1 in cycle N+1.
  - RD_LAT=2: output passes through one extra register; Q valid and rd_vld=1 in cycle N+2.
  - Back-to-back reads are fully pipelined at one per cycle.
- Q holds the last read data until the next read returns; it is never overwritten by writes or by the init sweep.
- Read-after-write to the same address in the next cycle returns the new data. No same-cycle forwarding (single port).
- Reset mid-sweep: asynchronously returns FSM to INIT with cnt=0, clears the read pipeline, and forces rd_vld to 0. Array contents already written are left as is.
- A read accepted in the last IDLE cycle before INIT still completes normally through the pipeline.

Optional Feature:
- Macro: CT_SPSRAM_ACC_CNT_EN.
- When defined:
  - Adds outputs rd_cnt[15:0] and wr_cnt[15:0].
  - Each counts accepted external reads and writes (CEN=0 outside INIT). A write counts even if WEN is all-ones.
  - Counters saturate at 16'hFFFF, reset to 0, and clear to 0 on the cycle the FSM enters INIT.
- When not defined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Reset release, ADDR_WIDTH=7 -> init_busy=1 for exactly 128 cycles; init_done pulses once; a read of any address returns 16'h0000.
- After init, write A=7'h05, D=16'hA5A5, WEN=16'h0000; then read A=7'h05 with RD_LAT=1 -> Q=16'hA5A5 with rd_vld high one cycle after the read. Repeat with RD_LAT=2 -> data appears two cycles after the read.
- Partial write: entry holds 16'hFFFF; write D=16'h0000 with WEN=16'hFF00 -> a subsequent read returns 16'hFF00.
- Back-to-back reads to addresses 0,1,2,3 holding 16'h0011, 16'h0022, 16'h0033, 16'h0044 -> Q shows the same values on consecutive cycles, with rd_vld high for 4 cycles.
- init_req in IDLE together with a write to 7'h10 of 16'h1234 -> the write lands, then is cleared by the sweep; reads issued during the sweep are dropped (rd_vld=0); after init_done, reading 7'h10 returns 16'h0000.
- Assert cpurst_b=0 at sweep cycle 40 -> Q=0, rd_vld=0 immediately; after release the sweep restarts from 0 and takes a full 128 cycles. With CT_SPSRAM_ACC_CNT_EN, 3 reads + 2 writes -> rd_cnt=3, wr_cnt=2.
